// File: rtl/gpio_in_conditioner_if.sv
// Host-side bundle of the GPIO input conditioner: filtered IO levels plus
// the change-event word and its valid/ack handshake.
interface gpio_in_conditioner_if #(
    parameter int IO_WIDTH = 34
);
    logic [IO_WIDTH-1:0] io_in;
    logic [IO_WIDTH-1:0] change_flags;
    logic                change_valid;
    logic                change_ack;

    // Conditioner side: produces levels and events, consumes the ack.
    modport master (
        output io_in,
        output change_flags,
        output change_valid,
        input  change_ack
    );

    // hostmot2 side: consumes levels and events, returns the ack.
    modport slave (
        input  io_in,
        input  change_flags,
        input  change_valid,
        output change_ack
    );
endinterface

// File: rtl/gpio_in_conditioner.sv
// DE0-Nano GPIO header input conditioner for hostmot2: maps 36 header pins
// onto 2 x 17 IO bits, synchronises and glitch-filters each bit, and hands
// coalesced level-change events to the host with a valid/ack handshake.
module gpio_in_conditioner #(
    parameter int GPIO_WIDTH = 36,
    parameter int PORT_WIDTH = 17,
    parameter int IO_WIDTH   = 2 * PORT_WIDTH,
    parameter int FILT_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    input  logic [FILT_BITS-1:0]  filt_len,
    gpio_in_conditioner_if.master host
);

    localparam logic [FILT_BITS-1:0] CNT_ONE = 1;
    localparam logic [FILT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [IO_WIDTH-1:0]  pin_mapped;
    logic [IO_WIDTH-1:0]  sync_q1;
    logic [IO_WIDTH-1:0]  sync_q2;
    logic [IO_WIDTH-1:0]  io_q;
    logic [IO_WIDTH-1:0]  toggles;
    logic [FILT_BITS-1:0] cnt_q [IO_WIDTH];
    logic [IO_WIDTH-1:0]  accum_q;
    logic [IO_WIDTH-1:0]  accum_d;
    logic [IO_WIDTH-1:0]  flags_q;
    logic [IO_WIDTH-1:0]  flags_d;
    state_t               state_q;
    state_t               state_d;

    // Header pin 17 sits between the two ports and pin 35 is past port 1;
    // neither carries an IO bit.
    logic unused_pins;
    assign unused_pins = ^{gpio_in[PORT_WIDTH], gpio_in[GPIO_WIDTH-1]};

    // Port 0 takes pins 0..16 directly; port 1 skips pin 17.
    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_map
        if (i < PORT_WIDTH) begin : g_port0
            assign pin_mapped[i] = gpio_in[i];
        end else begin : g_port1
            assign pin_mapped[i] = gpio_in[i+1];
        end
    end

    // Two-flop synchroniser bringing the asynchronous pins into the hm2 domain.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pin_mapped;
            sync_q2 <= sync_q1;
        end
    end

    // A bit flips once its mismatch has persisted past filt_len; >= lets a
    // lowered filt_len fire immediately on an already-long count.
    always_comb begin
        // NOTE: a default before the loop keeps every bit assigned on every
        // path, so no latch is inferred.
        toggles = '0;
        for (int i = 0; i < IO_WIDTH; i++) begin
            toggles[i] = (sync_q2[i] != io_q[i]) && (cnt_q[i] >= filt_len);
        end
    end

    // Per-bit stable-mismatch counters (saturating) and filtered levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the counter array is real per-bit state, not a RAM, so it
            // is cleared explicitly; stale counts would fire early after reset.
            for (int i = 0; i < IO_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            io_q <= '0;
        end else begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                if (sync_q2[i] == io_q[i] || toggles[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
            io_q <= io_q ^ toggles;
        end
    end

    // Handoff next-state: IDLE snapshots pending changes, PEND holds the
    // snapshot until acked while new toggles keep collecting in accum.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        accum_d = accum_q | toggles;
        case (state_q)
            IDLE: begin
                if ((accum_q | toggles) != '0) begin
                    flags_d = accum_q | toggles;
                    accum_d = '0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (host.change_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handoff state, snapshot and accumulator registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            flags_q <= '0;
            accum_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            accum_q <= accum_d;
        end
    end

    assign host.io_in        = io_q;
    assign host.change_flags = flags_q;
    assign host.change_valid = (state_q == PEND);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: filter/mapping vector table,
// hand-written handshake, filt_len and reset sequences, and an event
// scoreboard fed at stimulus time and drained on each change_valid rise.
module tb_gpio_in_conditioner;

    localparam int IO_W = 34;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [35:0] gpio_in = '0;
    logic [7:0]  filt_len = '0;

    int checks = 0;
    int errors = 0;

    logic [IO_W-1:0] exp_q[$];
    bit              prev_valid = 1'b0;

    gpio_in_conditioner_if #(.IO_WIDTH(IO_W)) bus ();

    gpio_in_conditioner dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .gpio_in  (gpio_in),
        .filt_len (filt_len),
        .host     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0]     gpio;
        logic [7:0]      flen;
        int              hold;
        logic [IO_W-1:0] exp_io;
        bit              exp_event;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gpio_in = '0;
        bus.change_ack = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.change_ack = 1'b1;
        cyc(1);
        bus.change_ack = 1'b0;
    endtask

    // Scoreboard drain: every new event must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.change_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event got flags 0x%0h expected no event",
                             bus.change_flags);
                end else begin
                    check("event_flags", bus.change_flags, exp_q.pop_front());
                end
            end
            prev_valid = bus.change_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IO_W-1:0] peak;
        int              first_k;

        vecs[0] = '{36'h0_0000_0020, 8'd3, 3, 34'h0_0000_0000, 1'b0};
        vecs[1] = '{36'h0_0000_0020, 8'd3, 4, 34'h0_0000_0020, 1'b1};
        vecs[2] = '{36'h0_0004_0000, 8'd0, 3, 34'h0_0002_0000, 1'b1};
        vecs[3] = '{36'h0_0002_0000, 8'd0, 3, 34'h0_0000_0000, 1'b0};
        vecs[4] = '{36'h8_0000_0000, 8'd0, 3, 34'h0_0000_0000, 1'b0};
        vecs[5] = '{36'h4_0001_0001, 8'd1, 2, 34'h2_0001_0001, 1'b1};
        vecs[6] = '{36'h0_0000_0400, 8'd2, 2, 34'h0_0000_0000, 1'b0};

        bus.change_ack = 1'b0;

        // Reset state, then release with every pin high.
        gpio_in  = '1;
        filt_len = 8'd4;
        cyc(3);
        check("rst_io_in", bus.io_in, 0);
        check("rst_valid", bus.change_valid, 0);
        check("rst_flags", bus.change_flags, 0);
        reset_n = 1'b1;
        exp_q.push_back(34'h3_FFFF_FFFF);
        cyc(6);
        check("rel_io_before", bus.io_in, 0);
        cyc(1);
        check("rel_io_at7", bus.io_in, 34'h3_FFFF_FFFF);
        cyc(1);
        check("rel_valid", bus.change_valid, 1);
        check("rel_flags", bus.change_flags, 34'h3_FFFF_FFFF);
        ack_pulse();
        gpio_in = 36'h7_FFFD_FFFF;
        cyc(6);
        check("unused_pins_io", bus.io_in, 34'h3_FFFF_FFFF);
        check("unused_pins_valid", bus.change_valid, 0);

        // Filter / mapping vectors with automatic acknowledge.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            filt_len = vecs[v].flen;
            if (vecs[v].exp_event) begin
                exp_q.push_back(vecs[v].exp_io);
                exp_q.push_back(vecs[v].exp_io);
            end
            peak    = '0;
            first_k = -1;
            gpio_in = vecs[v].gpio;
            for (int k = 1; k <= vecs[v].hold + int'(vecs[v].flen) + 12; k++) begin
                @(negedge clk);
                if (bus.io_in != '0 && first_k < 0) first_k = k;
                peak = peak | bus.io_in;
                bus.change_ack = bus.change_valid;
                if (k == vecs[v].hold) gpio_in = '0;
            end
            bus.change_ack = 1'b0;
            check($sformatf("vec%0d_peak", v), peak, vecs[v].exp_io);
            check($sformatf("vec%0d_final", v), bus.io_in, 0);
            if (vecs[v].exp_event) begin
                check($sformatf("vec%0d_latency", v), first_k, int'(vecs[v].flen) + 3);
            end
        end

        // Handshake coalescing.
        do_reset();
        filt_len = 8'd0;
        gpio_in  = 36'h1;
        exp_q.push_back(34'h1);
        cyc(3);
        check("hs_valid_first", bus.change_valid, 1);
        check("hs_flags_first", bus.change_flags, 34'h1);
        gpio_in = 36'h7;
        exp_q.push_back(34'h6);
        cyc(6);
        check("hs_io_pend", bus.io_in, 34'h7);
        check("hs_flags_held", bus.change_flags, 34'h1);
        check("hs_valid_held", bus.change_valid, 1);
        ack_pulse();
        check("hs_valid_gap", bus.change_valid, 0);
        cyc(1);
        check("hs_valid_second", bus.change_valid, 1);
        check("hs_flags_second", bus.change_flags, 34'h6);
        gpio_in = 36'hF;
        exp_q.push_back(34'h8);
        cyc(2);
        ack_pulse();
        check("coinc_valid_gap", bus.change_valid, 0);
        check("coinc_io", bus.io_in, 34'hF);
        check("coinc_flags_kept", bus.change_flags, 34'h6);
        cyc(1);
        check("coinc_valid", bus.change_valid, 1);
        check("coinc_flags", bus.change_flags, 34'h8);
        ack_pulse();
        bus.change_ack = 1'b1;
        cyc(2);
        bus.change_ack = 1'b0;
        check("idle_ack_ignored", bus.change_valid, 0);

        // Lowering filt_len below a running count fires on the next edge.
        do_reset();
        filt_len = 8'd20;
        gpio_in  = 36'h80;
        exp_q.push_back(34'h80);
        cyc(12);
        check("flen_counting", bus.io_in, 0);
        filt_len = 8'd5;
        cyc(1);
        check("flen_lowered_fire", bus.io_in, 34'h80);
        check("flen_valid", bus.change_valid, 1);

        // Asynchronous reset while an event is pending.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", bus.change_valid, 0);
        check("async_rst_flags", bus.change_flags, 0);
        check("async_rst_io", bus.io_in, 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(34'h80);
        cyc(7);
        check("post_rst_io_before", bus.io_in, 0);
        cyc(1);
        check("post_rst_io_rise", bus.io_in, 34'h80);
        ack_pulse();
        cyc(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Input-direction companion to the DE0-Nano board configuration: 36-pin GPIO expansion header -> 2 ports x 17 hostmot2 IO bits (34 total).
- Per bit: synchronises, glitch-filters with a programmable stable-count, then presents the filtered levels.
- Coalesces level changes into a change-event word, handed to the host side with a valid/ack handshake.
- Sits between the header pins and the hostmot2 IO input bus, in the hm2 clock domain.

Parameters:
- GPIO_WIDTH, 36, header pins sampled.
- PORT_WIDTH, 17, IO bits per port.
- IO_WIDTH, 34, total IO bits = 2*PORT_WIDTH.
- FILT_BITS, 8, width of filter length and per-bit counters.

Ports:
- clk  in  1  sole clock, hm2 domain.
- reset_n  in  1  asynchronous, active-low reset.
- gpio_in  in  GPIO_WIDTH  raw header pins, asynchronous to clk.
- filt_len  in  FILT_BITS  required stable-mismatch length; quasi-static, may change any time.
- io_in  out  IO_WIDTH  filtered, synchronised IO levels.
- change_flags  out  IO_WIDTH  snapshot of bits that toggled since the last handoff.
- change_valid  out  1  change_flags holds an unacknowledged event.
- change_ack  in  1  consumer accepted change_flags.

Behaviour:
- Pin mapping:
  - io bit i = gpio_in[i] for i=0..16 (port 0).
  - io bit i = gpio_in[i+1] for i=17..33 (port 1).
  - gpio_in[17] and gpio_in[35] are ignored.
- Reset (asynchronous assert, synchronous-to-clk release): all sync flops, counters, io_in, accumulator, change_flags = 0; change_valid = 0; FSM = IDLE.
- Synchroniser: 2 flops per bit. The sync value reflects a pin 2 clk edges after it settles.
- Filter, per bit, every cycle:
  - sync == io_in bit: counter <= 0.
  - else if counter >= filt_len: io_in bit toggles; counter <= 0; toggle pulse asserted that cycle (combinational from the update condition).
  - else: counter <= counter+1.
- Filter timing:
  - A clean pin step appears on io_in after exactly 2 + filt_len + 1 clk edges.
  - filt_len = 0 gives 3-cycle latency.
  - A mismatch shorter than filt_len+1 sync cycles is rejected: no io_in change, no flag.
- The >= comparison is required. Lowering filt_len below a running count fires on the next cycle. Raising it extends the count. The counter saturates at its maximum and never wraps.
- Event accumulator (IO_WIDTH bits): accum <= accum | toggles every cycle, except where the FSM loads it as described below.
- Handoff FSM, states IDLE and PEND:
  - IDLE, (accum|toggles) != 0: change_flags <= accum|toggles; accum <= 0; change_valid <= 1; -> PEND.
  - IDLE, otherwise: stay.
  - PEND: change_flags and change_valid held stable. New toggles go into accum only.
  - PEND, change_ack = 1: change_valid <= 0; change_flags retains its value; -> IDLE. IDLE may reload on the very next cycle, so minimum valid spacing is 1 idle cycle.
  - change_ack while IDLE is ignored.
- Simultaneous toggle and ack: the toggle goes to accum and is reported in the next event; it is never lost.
- Multiple toggles of one bit before handoff coalesce to one flag (toggle parity not preserved).
- Reset mid-operation: everything cleared immediately, in-flight event discarded. After release, pins already high produce io_in rise plus a flag after 2+filt_len+1 cycles.

Test Plan:
- Reset release with gpio_in = all-ones, filt_len = 4:
  - Required: io_in = 0x3_FFFF_FFFF exactly 7 cycles after the first edge, change_flags = 0x3_FFFF_FFFF, change_valid = 1 one cycle later.
  - Required: gpio 17/35 do not affect io_in.
- Glitch rejection, filt_len = 3, gpio_in[5] high for 3 cycles then low:
  - Required: io_in[5] stays 0, no change_valid.
  - Same with 4 cycles high: io_in[5] pulses 1, and change_flags bit 5 set.
- Mapping, filt_len = 0: drive gpio_in[18] high.
  - Required: io_in[17] = 1 after 3 cycles; driving gpio_in[17] alone changes nothing.
- Handshake coalescing:
  - Toggle bit 0; hold ack low; toggle bits 1 and 2 during PEND. Required: change_flags stays 0x1 until ack.
  - Then 1 cycle valid low, then change_flags = 0x6, valid high.
  - Toggle coincident with ack: that bit appears in the next event.
- filt_len change: count to 10 with filt_len = 20, then set filt_len = 5. Required: io_in toggles on the next cycle.
- Reset asserted while change_valid = 1. Required: change_valid, change_flags, io_in = 0 asynchronously, without waiting for a clk edge.
